// File: rtl/vx_warp_ctl_unit.sv
// Warp control unit: tracks active/stalled warps, per-warp thread masks,
// warp spawning and a small barrier table. Requests from the GPU unit are
// applied in tmc > wspawn > bar priority; a ctl clear beats a same-warp stall.
module vx_warp_ctl_unit #(
   parameter int          NUM_WARPS    = 4,
   parameter int          NUM_THREADS  = 4,
   parameter int          NUM_BARRIERS = 4,
   parameter logic [31:0] STARTUP_ADDR = 32'h80000000,
   localparam int         NW_BITS      = $clog2(NUM_WARPS),
   localparam int         NB_BITS      = $clog2(NUM_BARRIERS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             stall_valid,
   input  logic [NW_BITS-1:0]               stall_wid,
   input  logic                             ctl_valid,
   input  logic [NW_BITS-1:0]               ctl_wid,
   input  logic                             tmc_valid,
   input  logic [NUM_THREADS-1:0]           tmc_tmask,
   input  logic                             wspawn_valid,
   input  logic [NUM_WARPS-1:0]             wspawn_wmask,
   input  logic [31:0]                      wspawn_pc,
   input  logic                             bar_valid,
   input  logic [NB_BITS-1:0]               bar_id,
   input  logic [NW_BITS-1:0]               bar_size_m1,
   output logic [NUM_WARPS-1:0]             active_warps,
   output logic [NUM_WARPS-1:0]             stalled_warps,
   output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
   output logic [NUM_WARPS-1:0]             schedulable,
   output logic                             spawn_valid,
   output logic [NUM_WARPS-1:0]             spawn_wmask,
   output logic [31:0]                      spawn_pc,
   output logic                             busy
);

   localparam logic [NUM_WARPS-1:0]   WARP0_BIT   = NUM_WARPS'(1);
   localparam logic [NUM_THREADS-1:0] THREAD0_BIT = NUM_THREADS'(1);

   logic [NUM_WARPS-1:0]             active_n;
   logic [NUM_WARPS-1:0]             stalled_n;
   logic [NUM_WARPS*NUM_THREADS-1:0] tmasks_n;
   logic                             spawn_valid_n;
   logic [NUM_WARPS-1:0]             spawn_wmask_n;
   logic [31:0]                      spawn_pc_n;
   logic [NW_BITS-1:0]               bar_cnt   [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]             bar_mask  [NUM_BARRIERS];
   logic [NW_BITS-1:0]               bar_cnt_n [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]             bar_mask_n[NUM_BARRIERS];
   logic [NUM_WARPS-1:0]             ctl_bit;

   assign ctl_bit = WARP0_BIT << ctl_wid;

   // Next-state: stall request first, then the single highest-priority ctl op so its clear wins
   always_comb begin
      active_n      = active_warps;
      stalled_n     = stalled_warps;
      tmasks_n      = thread_masks;
      spawn_valid_n = 1'b0;
      spawn_wmask_n = spawn_wmask;
      spawn_pc_n    = spawn_pc;
      bar_cnt_n     = bar_cnt;
      bar_mask_n    = bar_mask;

      if (stall_valid) begin
         stalled_n[stall_wid] = 1'b1;
      end

      if (ctl_valid) begin
         if (tmc_valid) begin
            tmasks_n[ctl_wid*NUM_THREADS +: NUM_THREADS] = tmc_tmask;
            stalled_n[ctl_wid] = 1'b0;
            if (tmc_tmask == '0) begin
               active_n[ctl_wid] = 1'b0;
            end
         end else if (wspawn_valid) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
               if (wspawn_wmask[w] && (NW_BITS'(w) != ctl_wid)) begin
                  active_n[w]  = 1'b1;
                  stalled_n[w] = 1'b0;
                  tmasks_n[w*NUM_THREADS +: NUM_THREADS] = THREAD0_BIT;
               end
            end
            stalled_n[ctl_wid] = 1'b0;
            spawn_valid_n      = 1'b1;
            spawn_wmask_n      = wspawn_wmask & ~ctl_bit;
            spawn_pc_n         = wspawn_pc;
         end else if (bar_valid) begin
            if (bar_cnt[bar_id] == bar_size_m1) begin
               stalled_n          = stalled_n & ~(bar_mask[bar_id] | ctl_bit);
               bar_cnt_n[bar_id]  = '0;
               bar_mask_n[bar_id] = '0;
            end else begin
               bar_cnt_n[bar_id]  = bar_cnt[bar_id] + NW_BITS'(1);
               bar_mask_n[bar_id] = bar_mask[bar_id] | ctl_bit;
            end
         end
      end
   end

   // State registers with synchronous active-low reset that also drops any pending spawn pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         active_warps  <= WARP0_BIT;
         stalled_warps <= '0;
         thread_masks  <= {{((NUM_WARPS-1)*NUM_THREADS){1'b0}}, THREAD0_BIT};
         spawn_valid   <= 1'b0;
         spawn_wmask   <= '0;
         spawn_pc      <= STARTUP_ADDR;
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            bar_cnt[b]  <= '0;
            bar_mask[b] <= '0;
         end
      end else begin
         active_warps  <= active_n;
         stalled_warps <= stalled_n;
         thread_masks  <= tmasks_n;
         spawn_valid   <= spawn_valid_n;
         spawn_wmask   <= spawn_wmask_n;
         spawn_pc      <= spawn_pc_n;
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            bar_cnt[b]  <= bar_cnt_n[b];
            bar_mask[b] <= bar_mask_n[b];
         end
      end
   end

   // A warp can issue when it is active, not stalled and has at least one live thread
   always_comb begin
      schedulable = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         schedulable[w] = active_warps[w] & ~stalled_warps[w]
                        & (|thread_masks[w*NUM_THREADS +: NUM_THREADS]);
      end
   end

   assign busy = |active_warps;

endmodule

// File: tb/tb_vx_warp_ctl_unit.sv
// Directed self-checking bench for vx_warp_ctl_unit (default parameters).
module tb_vx_warp_ctl_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_valid;
   logic [1:0]  stall_wid;
   logic        ctl_valid;
   logic [1:0]  ctl_wid;
   logic        tmc_valid;
   logic [3:0]  tmc_tmask;
   logic        wspawn_valid;
   logic [3:0]  wspawn_wmask;
   logic [31:0] wspawn_pc;
   logic        bar_valid;
   logic [1:0]  bar_id;
   logic [1:0]  bar_size_m1;
   logic [3:0]  active_warps;
   logic [3:0]  stalled_warps;
   logic [15:0] thread_masks;
   logic [3:0]  schedulable;
   logic        spawn_valid;
   logic [3:0]  spawn_wmask;
   logic [31:0] spawn_pc;
   logic        busy;

   int total = 0;
   int bad   = 0;

   vx_warp_ctl_unit dut (
      .clk(clk), .reset(reset),
      .stall_valid(stall_valid), .stall_wid(stall_wid),
      .ctl_valid(ctl_valid), .ctl_wid(ctl_wid),
      .tmc_valid(tmc_valid), .tmc_tmask(tmc_tmask),
      .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
      .bar_valid(bar_valid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
      .active_warps(active_warps), .stalled_warps(stalled_warps),
      .thread_masks(thread_masks), .schedulable(schedulable),
      .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
      .busy(busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task idle();
      stall_valid = 0; stall_wid = 0; ctl_valid = 0; ctl_wid = 0;
      tmc_valid = 0; tmc_tmask = 0; wspawn_valid = 0; wspawn_wmask = 0;
      wspawn_pc = 0; bar_valid = 0; bar_id = 0; bar_size_m1 = 0;
   endtask

   // One edge, then sample point 1 ns later with inputs returned to idle
   task tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task drive_stall(input logic [1:0] w);
      stall_valid = 1; stall_wid = w;
      tick();
   endtask

   task drive_tmc(input logic [1:0] w, input logic [3:0] m);
      ctl_valid = 1; ctl_wid = w; tmc_valid = 1; tmc_tmask = m;
      tick();
   endtask

   task drive_spawn(input logic [1:0] w, input logic [3:0] m, input logic [31:0] pc);
      ctl_valid = 1; ctl_wid = w; wspawn_valid = 1; wspawn_wmask = m; wspawn_pc = pc;
      tick();
   endtask

   task drive_bar(input logic [1:0] w, input logic [1:0] id, input logic [1:0] szm1);
      ctl_valid = 1; ctl_wid = w; bar_valid = 1; bar_id = id; bar_size_m1 = szm1;
      tick();
   endtask

   task test_reset();
      idle();
      reset = 0;
      tick();
      tick();
      reset = 1;
      tick();
      total++; if (active_warps !== 4'b0001) begin bad++; $display("[TB] FAIL reset_active got=%b exp=%b", active_warps, 4'b0001); end
      total++; if (thread_masks !== 16'h0001) begin bad++; $display("[TB] FAIL reset_tmask got=%h exp=%h", thread_masks, 16'h0001); end
      total++; if (stalled_warps !== 4'b0000) begin bad++; $display("[TB] FAIL reset_stalled got=%b exp=%b", stalled_warps, 4'b0000); end
      total++; if (schedulable !== 4'b0001) begin bad++; $display("[TB] FAIL reset_sched got=%b exp=%b", schedulable, 4'b0001); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=1", busy); end
      total++; if (spawn_valid !== 1'b0 || spawn_wmask !== 4'b0000) begin bad++; $display("[TB] FAIL reset_spawn got=%b/%b exp=0/0000", spawn_valid, spawn_wmask); end
      total++; if (spawn_pc !== 32'h80000000) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", spawn_pc, 32'h80000000); end
   endtask

   task test_spawn();
      drive_stall(2'd0);
      total++; if (stalled_warps !== 4'b0001 || schedulable !== 4'b0000) begin bad++; $display("[TB] FAIL stall0 got=%b/%b exp=0001/0000", stalled_warps, schedulable); end
      drive_spawn(2'd0, 4'b1111, 32'h80000100);
      total++; if (active_warps !== 4'b1111) begin bad++; $display("[TB] FAIL spawn_active got=%b exp=1111", active_warps); end
      total++; if (stalled_warps !== 4'b0000) begin bad++; $display("[TB] FAIL spawn_stalled got=%b exp=0000", stalled_warps); end
      total++; if (thread_masks !== 16'h1111) begin bad++; $display("[TB] FAIL spawn_tmask got=%h exp=1111", thread_masks); end
      total++; if (spawn_valid !== 1'b1 || spawn_wmask !== 4'b1110) begin bad++; $display("[TB] FAIL spawn_pulse got=%b/%b exp=1/1110", spawn_valid, spawn_wmask); end
      total++; if (spawn_pc !== 32'h80000100) begin bad++; $display("[TB] FAIL spawn_pc got=%h exp=80000100", spawn_pc); end
      tick();
      total++; if (spawn_valid !== 1'b0) begin bad++; $display("[TB] FAIL spawn_pulse_end got=%b exp=0", spawn_valid); end
   endtask

   task test_barrier();
      for (int w = 0; w < 4; w++) drive_stall(2'(w));
      total++; if (stalled_warps !== 4'b1111) begin bad++; $display("[TB] FAIL bar_allstall got=%b exp=1111", stalled_warps); end
      drive_bar(2'd1, 2'd2, 2'd3);
      drive_bar(2'd3, 2'd2, 2'd3);
      drive_bar(2'd0, 2'd2, 2'd3);
      total++; if (stalled_warps !== 4'b1111 || schedulable !== 4'b0000) begin bad++; $display("[TB] FAIL bar_wait got=%b/%b exp=1111/0000", stalled_warps, schedulable); end
      drive_bar(2'd2, 2'd2, 2'd3);
      total++; if (stalled_warps !== 4'b0000 || schedulable !== 4'b1111) begin bad++; $display("[TB] FAIL bar_release got=%b/%b exp=0000/1111", stalled_warps, schedulable); end
      // Entry 2 must restart at zero: a 2-warp barrier now needs two arrivals
      drive_stall(2'd1);
      drive_stall(2'd3);
      drive_bar(2'd1, 2'd2, 2'd1);
      total++; if (stalled_warps !== 4'b1010) begin bad++; $display("[TB] FAIL bar_reuse_wait got=%b exp=1010", stalled_warps); end
      drive_bar(2'd3, 2'd2, 2'd1);
      total++; if (stalled_warps !== 4'b0000) begin bad++; $display("[TB] FAIL bar_reuse_release got=%b exp=0000", stalled_warps); end
   endtask

   task test_tmc();
      drive_tmc(2'd1, 4'b0000);
      total++; if (active_warps !== 4'b1101 || schedulable !== 4'b1101) begin bad++; $display("[TB] FAIL tmc_w1 got=%b/%b exp=1101/1101", active_warps, schedulable); end
      total++; if (thread_masks !== 16'h1101) begin bad++; $display("[TB] FAIL tmc_w1_tmask got=%h exp=1101", thread_masks); end
      drive_tmc(2'd2, 4'b0000);
      drive_tmc(2'd3, 4'b0000);
      total++; if (active_warps !== 4'b0001 || busy !== 1'b1) begin bad++; $display("[TB] FAIL tmc_w23 got=%b/%b exp=0001/1", active_warps, busy); end
      drive_tmc(2'd0, 4'b0000);
      total++; if (active_warps !== 4'b0000 || busy !== 1'b0) begin bad++; $display("[TB] FAIL tmc_idle got=%b/%b exp=0000/0", active_warps, busy); end
   endtask

   task test_back_to_back();
      // Request from an inactive warp still takes effect
      drive_spawn(2'd1, 4'b0101, 32'h00000040);
      total++; if (active_warps !== 4'b0101 || thread_masks !== 16'h0101) begin bad++; $display("[TB] FAIL inactive_spawn got=%b/%h exp=0101/0101", active_warps, thread_masks); end
      total++; if (spawn_valid !== 1'b1 || spawn_wmask !== 4'b0101 || spawn_pc !== 32'h00000040) begin bad++; $display("[TB] FAIL inactive_spawn_pulse got=%b/%b/%h exp=1/0101/00000040", spawn_valid, spawn_wmask, spawn_pc); end
      stall_valid = 1; stall_wid = 2'd2;
      drive_tmc(2'd2, 4'b0011);
      total++; if (stalled_warps !== 4'b0000 || thread_masks !== 16'h0301) begin bad++; $display("[TB] FAIL same_warp got=%b/%h exp=0000/0301", stalled_warps, thread_masks); end
      stall_valid = 1; stall_wid = 2'd0;
      drive_tmc(2'd2, 4'b0011);
      total++; if (stalled_warps !== 4'b0001 || schedulable !== 4'b0100) begin bad++; $display("[TB] FAIL diff_warp got=%b/%b exp=0001/0100", stalled_warps, schedulable); end
      drive_bar(2'd0, 2'd3, 2'd0);
      total++; if (stalled_warps !== 4'b0000 || schedulable !== 4'b0101) begin bad++; $display("[TB] FAIL bar_size1 got=%b/%b exp=0000/0101", stalled_warps, schedulable); end
      // tmc beats wspawn and bar in the same cycle
      ctl_valid = 1; ctl_wid = 2'd0; tmc_valid = 1; tmc_tmask = 4'b1111;
      wspawn_valid = 1; wspawn_wmask = 4'b1111; wspawn_pc = 32'h12345678;
      bar_valid = 1; bar_id = 2'd0; bar_size_m1 = 2'd0;
      tick();
      total++; if (thread_masks !== 16'h030F || active_warps !== 4'b0101 || spawn_valid !== 1'b0) begin bad++; $display("[TB] FAIL priority got=%h/%b/%b exp=030f/0101/0", thread_masks, active_warps, spawn_valid); end
   endtask

   task test_reset_mid();
      drive_stall(2'd0);
      drive_stall(2'd2);
      drive_bar(2'd0, 2'd1, 2'd2);
      drive_bar(2'd2, 2'd1, 2'd2);
      total++; if (stalled_warps !== 4'b0101) begin bad++; $display("[TB] FAIL mid_wait got=%b exp=0101", stalled_warps); end
      reset = 0;
      ctl_valid = 1; ctl_wid = 2'd0; wspawn_valid = 1; wspawn_wmask = 4'b1111; wspawn_pc = 32'h00001234;
      tick();
      reset = 1;
      total++; if (spawn_valid !== 1'b0 || spawn_wmask !== 4'b0000 || spawn_pc !== 32'h80000000) begin bad++; $display("[TB] FAIL mid_spawn got=%b/%b/%h exp=0/0000/80000000", spawn_valid, spawn_wmask, spawn_pc); end
      total++; if (active_warps !== 4'b0001 || stalled_warps !== 4'b0000 || thread_masks !== 16'h0001) begin bad++; $display("[TB] FAIL mid_state got=%b/%b/%h exp=0001/0000/0001", active_warps, stalled_warps, thread_masks); end
      drive_stall(2'd0);
      drive_stall(2'd2);
      drive_bar(2'd0, 2'd1, 2'd1);
      total++; if (stalled_warps !== 4'b0101) begin bad++; $display("[TB] FAIL mid_rearrive got=%b exp=0101", stalled_warps); end
      drive_bar(2'd1, 2'd1, 2'd1);
      total++; if (stalled_warps !== 4'b0100) begin bad++; $display("[TB] FAIL mid_release got=%b exp=0100", stalled_warps); end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_barrier();
      test_tmc();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vx_warp_ctl_unit.md
VX_WARP_CTL_UNIT -- requirements
Module: VX_warp_ctl_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps (power of 2, ≥2); NW_BITS = log2(NUM_WARPS).
REQ-002 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-003 SHALL have parameter NUM_BARRIERS, default 4, barrier table entries (power of 2); NB_BITS = log2(NUM_BARRIERS).
REQ-004 SHALL have parameter STARTUP_ADDR, default 32'h80000000, warp-0 PC at reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-007 stall_valid  input  1  issue stage dispatched a warp-control instruction; stall warp stall_wid.
REQ-008 stall_wid  input  NW_BITS  warp to stall.
REQ-009 ctl_valid  input  1  warp-control result from the GPU unit; no ready, accepted every cycle.
REQ-010 ctl_wid  input  NW_BITS  warp that executed the control instruction.
REQ-011 tmc_valid, tmc_tmask  input  1, NUM_THREADS  thread-mask change.
REQ-012 wspawn_valid, wspawn_wmask, wspawn_pc  input  1, NUM_WARPS, 32  warp spawn.
REQ-013 bar_valid, bar_id, bar_size_m1  input  1, NB_BITS, NW_BITS  barrier arrival; size = bar_size_m1+1 warps.
REQ-014 active_warps  output  NUM_WARPS  registered active mask.
REQ-015 stalled_warps  output  NUM_WARPS  registered stalled mask.
REQ-016 thread_masks  output  NUM_WARPS*NUM_THREADS  registered per-warp thread masks, warp w at bits [w*NUM_THREADS +: NUM_THREADS].
REQ-017 schedulable  output  NUM_WARPS  combinational: active & ~stalled & (thread mask ≠ 0), per warp.
REQ-018 spawn_valid, spawn_wmask, spawn_pc  output  1, NUM_WARPS, 32  registered one-cycle PC-load pulse to the fetch stage.
REQ-019 busy  output  1  combinational OR of active_warps.

Function
REQ-020 Sub-requests are qualified by ctl_valid; at most one of tmc/wspawn/bar is expected per cycle; if several, only the highest priority tmc > wspawn > bar SHALL take effect.
REQ-021 stall_valid SHALL set stalled[stall_wid] on the next edge.
REQ-022 tmc: thread_masks[ctl_wid] <= tmc_tmask; stalled[ctl_wid] <= 0; if tmc_tmask == 0, active[ctl_wid] <= 0.
REQ-023 wspawn: for every w with wspawn_wmask[w]=1 and w ≠ ctl_wid: active[w] <= 1, thread_masks[w] <= 1 (thread 0 only), stalled[w] <= 0; stalled[ctl_wid] <= 0.
REQ-024 wspawn SHALL pulse spawn_valid=1 on the cycle after acceptance, with spawn_wmask = wspawn_wmask & ~(1<<ctl_wid) and spawn_pc = wspawn_pc; spawn_valid = 0 otherwise.
REQ-025 Barrier table entry per id: count (NW_BITS) and waiting mask (NUM_WARPS), both 0 at reset.
REQ-026 bar with count[bar_id] ≠ bar_size_m1: count++, mask[bar_id] |= (1<<ctl_wid), ctl_wid stays stalled.
REQ-027 bar with count[bar_id] == bar_size_m1 (release): stalled &= ~(mask[bar_id] | 1<<ctl_wid); count and mask of bar_id <= 0; other entries untouched.
REQ-028 bar_size_m1 == 0 SHALL release the arriving warp immediately (same-edge unstall).
REQ-029 stall_valid and a ctl clear on the same warp in the same cycle: clear SHALL win; on different warps both apply.
REQ-030 Latency: every state effect visible on outputs exactly one cycle after the input edge; schedulable follows combinationally.
REQ-031 Control requests from inactive warps SHALL be applied as specified (no filtering).

Reset
REQ-032 While reset=0 at an edge: active_warps = 1 (warp 0), thread_masks = warp 0 = 1, others 0, stalled_warps = 0, all barrier entries 0, spawn_valid = 0, spawn_wmask = 0, spawn_pc = STARTUP_ADDR.
REQ-033 Reset asserted mid-barrier or mid-spawn SHALL discard all pending state, including an in-flight spawn pulse.

Verification
REQ-034 Reset release -> active=4'b0001, tmask[0]=4'b0001, stalled=0, schedulable=4'b0001, busy=1.
REQ-035 stall wid0, then wspawn wid0 wmask=4'b1111 pc=0x80000100 -> next cycle active=4'b1111, stalled=0, spawn_valid=1, spawn_wmask=4'b1110, spawn_pc=0x80000100; pulse gone the cycle after.
REQ-036 Warps 0..3 stalled, bar id=2 size_m1=3 from wid 1,3,0 -> all remain stalled, count[2]=3; bar from wid2 -> stalled=0, count[2]=0, mask[2]=0.
REQ-037 tmc wid1 tmask=0 -> active[1]=0, schedulable[1]=0; tmc wid0 tmask=0 with all others inactive -> busy=0.
REQ-038 Same cycle stall_valid wid2 and ctl tmc wid2 tmask=4'b0011 -> stalled[2]=0, tmask[2]=4'b0011; bar size_m1=0 -> immediate unstall.
REQ-039 reset=0 asserted with 2 warps waiting on barrier 1 -> reset state of REQ-032; later arrival on barrier 1 starts count from 0.
